fpa_issue_arbiter: RTL and testbench

//  Shares one free-running, unstallable FP adder (fixed LAT-cycle latency) among N_REQ VLIW issue lanes.

---
 rtl/fpa_ctrl_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/fpa_issue_arbiter.sv | 112 +++++++++++
 tb/tb_fpa_issue_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpa_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fpa_ctrl_pkg
//   Shared constants and types for the FP-adder issue control logic.
//   FPA_LAT : adder latency in cycles, counted from the issue handshake
//   FP_DW   : operand/result width (IEEE-754 single)
//   TAG_W   : destination-register tag width
//   LANE_W  : lane index width, wide enough for up to 8 issue lanes
//   fpa_shadow_t : {valid, lane, tag} bookkeeping that travels beside an op
// -----------------------------------------------------------------------------
package fpa_ctrl_pkg;

   localparam int FPA_LAT = 4;
   localparam int FP_DW   = 32;
   localparam int TAG_W   = 5;
   localparam int LANE_W  = 3;

   typedef struct packed {
      logic              valid;
      logic [LANE_W-1:0] lane;
      logic [TAG_W-1:0]  tag;
   } fpa_shadow_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search starts at ptr+1 and wraps, so
//   the lane named by ptr (the previous winner) has the lowest priority.
//   Ports:
//     req   in  N   request vector
//     ptr   in  IW  index of the last granted lane
//     grant out N   one-hot winner (all zero when nothing requests)
//     idx   out IW  encoded winner
//     any   out 1   some lane won
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   function automatic int lane_at(input logic [IW-1:0] p, input int k);
      return (int'(p) + k) % N;
   endfunction

   always_comb begin
      // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!any && req[lane_at(ptr, k)]) begin
            any                   = 1'b1;
            grant[lane_at(ptr, k)] = 1'b1;
            idx                   = IW'(lane_at(ptr, k));
         end
      end
   end

endmodule

// File: rtl/fpa_issue_arbiter.sv
// -----------------------------------------------------------------------------
// fpa_issue_arbiter
//   Shares one free-running FP adder among N_REQ issue lanes. One lane per
//   cycle is granted round-robin; its operands are registered into the adder
//   and {lane, tag} ride a LAT-deep shadow pipe so that each sum is routed back
//   to the lane that issued it. The operand register is the first of the LAT
//   cycles, the shadow stages 1..LAT-1 cover the adder's internal stages.
//   Ports:
//     clk, rst_n          clock / asynchronous active-low reset
//     flush               kill every in-flight op, block this cycle's grant
//     req_valid/sub/a/b/tag  per-lane request (lane i at [i*W +: W])
//     req_ready           one-hot grant
//     fpa_a, fpa_b        registered adder operands (B sign flipped for sub)
//     fpa_sum             adder result
//     rsp_valid/data/tag  one-hot returning lane, its sum and tag
//     busy                any op in flight
// -----------------------------------------------------------------------------
module fpa_issue_arbiter
   import fpa_ctrl_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int LAT   = FPA_LAT,
   parameter int DW    = FP_DW,
   parameter int TAGW  = TAG_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ-1:0]      req_sub,
   input  logic [N_REQ*DW-1:0]   req_a,
   input  logic [N_REQ*DW-1:0]   req_b,
   input  logic [N_REQ*TAGW-1:0] req_tag,
   output logic [N_REQ-1:0]      req_ready,
   output logic [DW-1:0]         fpa_a,
   output logic [DW-1:0]         fpa_b,
   input  logic [DW-1:0]         fpa_sum,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [DW-1:0]         rsp_data,
   output logic [TAGW-1:0]       rsp_tag,
   output logic                  busy
);

   localparam int IW = $clog2(N_REQ);

   logic [IW-1:0]    ptr;
   logic [N_REQ-1:0] win_onehot;
   logic [IW-1:0]    win_idx;
   logic             win_any;
   logic             hs;
   fpa_shadow_t      shadow [LAT];

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (win_onehot),
      .idx   (win_idx),
      .any   (win_any)
   );

   // A flush cycle never grants, so a mispredicted op cannot slip in behind it.
   assign req_ready = flush ? '0 : win_onehot;
   assign hs        = win_any & ~flush;

   // Operands and pointer only move on a handshake; otherwise they hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= IW'(N_REQ - 1);
         fpa_a <= '0;
         fpa_b <= '0;
      end else if (hs) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         ptr   <= win_idx;
         fpa_a <= req_a[win_idx*DW +: DW];
         fpa_b <= req_b[win_idx*DW +: DW] ^ {req_sub[win_idx], {(DW-1){1'b0}}};
      end
   end

   // Shadow pipe: shifts every cycle, never stalls; flush clears the valids.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: only the valid bits need reset; lane/tag are ignored while invalid.
         for (int k = 0; k < LAT; k++) shadow[k].valid <= 1'b0;
      end else begin
         shadow[0].valid <= hs;
         shadow[0].lane  <= LANE_W'(win_idx);
         shadow[0].tag   <= req_tag[win_idx*TAGW +: TAGW];
         for (int k = 1; k < LAT; k++) begin
            shadow[k]       <= shadow[k-1];
            shadow[k].valid <= shadow[k-1].valid & ~flush;
         end
      end
   end

   // The last stage is committed: it still returns even in a flush cycle.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      rsp_tag   = '0;
      if (shadow[LAT-1].valid) begin
         rsp_valid[shadow[LAT-1].lane[IW-1:0]] = 1'b1;
         rsp_data                              = fpa_sum;
         rsp_tag                               = shadow[LAT-1].tag;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < LAT; k++) busy = busy | shadow[k].valid;
   end

endmodule

// File: tb/tb_fpa_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpa_issue_arbiter
//   Directed stimulus with hand-computed sums per lane. Each expected grant is
//   compared on the spot; each expected response is queued and a separate
//   monitor pops and compares whenever rsp_valid is set. The adder stand-in is
//   a behavioural FP add behind LAT-1 registers (the operand register inside
//   the DUT supplies the first of the LAT cycles).
// -----------------------------------------------------------------------------
module tb_fpa_issue_arbiter;

   localparam int N   = 4;
   localparam int LAT = 4;
   localparam int DW  = 32;
   localparam int TW  = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_sub = '0;
   logic [N*DW-1:0] req_a = '0;
   logic [N*DW-1:0] req_b = '0;
   logic [N*TW-1:0] req_tag = '0;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   fpa_a, fpa_b, fpa_sum;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic [TW-1:0]   rsp_tag;
   logic            busy;

   fpa_issue_arbiter #(.N_REQ(N), .LAT(LAT), .DW(DW), .TAGW(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_sub   (req_sub),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .req_ready (req_ready),
      .fpa_a     (fpa_a),
      .fpa_b     (fpa_b),
      .fpa_sum   (fpa_sum),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural FP adder ----------------
   function automatic real f2r(input logic [31:0] f);
      real m;
      int  e;
      if (f[30:0] == 31'd0) return 0.0;
      m = 1.0 + real'(f[22:0]) / 8388608.0;
      e = int'(f[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return f[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   logic [DW-1:0] sum_pipe [LAT-1];
   always @(posedge clk) begin
      sum_pipe[0] <= r2f(f2r(fpa_a) + f2r(fpa_b));
      for (int k = 1; k < LAT-1; k++) sum_pipe[k] <= sum_pipe[k-1];
   end
   assign fpa_sum = sum_pipe[LAT-2];

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   typedef struct {
      logic [N-1:0]  lane;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] hand_sum [N];

   // Monitor: one response per rsp_valid, in issue order, exactly LAT cycles after issue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (rsp_valid != '0) begin
            if (sb.size() == 0) check("spurious rsp_valid", rsp_valid, '0);
            else begin
               e = sb.pop_front();
               check("response {valid,tag,data,cycle}",
                     {rsp_valid, rsp_tag, rsp_data, cyc}, {e.lane, e.tag, e.data, e.cyc});
            end
         end else begin
            check("idle rsp_tag/rsp_data", {rsp_tag, rsp_data}, '0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_lane(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic sub, input logic [TW-1:0] tag, input logic [DW-1:0] sum);
      req_a[i*DW +: DW]   = a;
      req_b[i*DW +: DW]   = b;
      req_sub[i]          = sub;
      req_tag[i*TW +: TW] = tag;
      hand_sum[i]         = sum;
   endtask

   // Drives one cycle (called just after a rising edge), checks the grant, queues the response.
   task automatic step(input logic [N-1:0] v, input logic fl, input logic [N-1:0] exp_rdy,
                       input int exp_busy);
      req_valid = v;
      flush     = fl;
      @(negedge clk);
      check("req_ready", req_ready, exp_rdy);
      if (exp_busy >= 0) check("busy", busy, exp_busy[0]);
      for (int i = 0; i < N; i++)
         if (exp_rdy[i]) sb.push_back('{exp_rdy, req_tag[i*TW +: TW], hand_sum[i], cyc + LAT});
      if (fl)
         for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc > cyc) sb.delete(i);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0, '0, -1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Per-lane operands with hand-computed sums.
      set_lane(0, 32'h461C4000, 32'hC5FA0000, 1'b0, 5'h03, 32'h44FA0000); // 10000 + -8000 = 2000
      set_lane(1, 32'h3F800000, 32'h40000000, 1'b0, 5'h11, 32'h40400000); // 1 + 2 = 3
      set_lane(2, 32'h411C0000, 32'h3F100000, 1'b0, 5'h1E, 32'h41250000); // 9.75 + 0.5625 = 10.3125
      set_lane(3, 32'h40A00000, 32'h3F800000, 1'b1, 5'h07, 32'h40800000); // 5 - 1 = 4

      repeat (2) @(posedge clk);
      #1;
      check("reset fpa_a/fpa_b", {fpa_a, fpa_b}, '0);
      check("reset rsp/busy", {rsp_valid, rsp_data, rsp_tag, busy}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Lane 0 alone: reset pointer gives lane 0 first priority.
      step(4'b0001, 1'b0, 4'b0001, 0);
      step(4'b0000, 1'b0, 4'b0000, 1);
      idle(5);

      // Lane 2 add then sub, back to back (9.75 - 0.5625 = 9.1875 = 0x41130000).
      step(4'b0100, 1'b0, 4'b0100, -1);
      set_lane(2, 32'h411C0000, 32'h3F100000, 1'b1, 5'h1E, 32'h41130000);
      step(4'b0100, 1'b0, 4'b0100, -1);
      idle(5);

      // Lane 3 alone moves the pointer to 3, then all lanes for 8 cycles.
      step(4'b1000, 1'b0, 4'b1000, -1);
      for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 4'((1 << (i % 4))), -1);
      idle(5);

      // Pointer to 1, then lanes 1 and 3 -> 3 then 1; lane 1 alone every cycle.
      step(4'b0010, 1'b0, 4'b0010, -1);
      step(4'b1010, 1'b0, 4'b1000, -1);
      step(4'b1010, 1'b0, 4'b0010, -1);
      for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 4'b0010, -1);
      idle(5);
      step(4'b0000, 1'b0, 4'b0000, 0);

      // Flush: three ops, one idle, flush while the first sits at the last stage.
      step(4'b0001, 1'b0, 4'b0001, -1);
      step(4'b0100, 1'b0, 4'b0100, -1);
      step(4'b1000, 1'b0, 4'b1000, -1);
      step(4'b0000, 1'b0, 4'b0000, 1);
      step(4'b1111, 1'b1, 4'b0000, 1);
      step(4'b0000, 1'b0, 4'b0000, 0);
      step(4'b1111, 1'b0, 4'b0001, -1);   // pointer held at 3 through the flush
      idle(5);

      // Async reset with four ops in flight.
      for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, 4'((1 << ((i + 1) % 4))), -1);
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check("in-reset fpa_a/fpa_b", {fpa_a, fpa_b}, '0);
      check("in-reset outputs", {req_ready, rsp_valid, rsp_data, rsp_tag, busy}, '0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step(4'b0000, 1'b0, 4'b0000, 0);
      step(4'b1111, 1'b0, 4'b0001, -1);   // pointer back at N-1 after reset
      idle(5);
      step(4'b0000, 1'b0, 4'b0000, 0);

      check("scoreboard drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
